fifo_rd_stream_adapter: RTL and testbench
=========================================

# fifo_rd_stream_adapter

Read-side adapter that sits directly downstream of the synchronous FIFO. It drives the FIFO's read enable and converts the FIFO's registered, one-cycle-latency read port into a valid/ready output stream. A 3-entry internal skid buffer sustains one word per cycle under continuous `m_ready` and tolerates arbitrary backpressure with no word loss or duplication, using only registered control (no `m_ready` → `fifo_r_en` combinational path).

## Interface
- `fifo_width`, 16, data word width; must match the FIFO's `fifo_width`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_r_en`  output  1  FIFO read enable.
- `fifo_data`  input  `fifo_width`  FIFO `data_out`.
- `m_valid`  output  1  output word available.
- `m_ready`  input  1  downstream accepts the word.
- `m_data`  output  `fifo_width`  output word (head of skid buffer).
- `word_count`  output  32  accepted-beat counter (see Configuration).

## Operation
- State:
  - `cnt[1:0]`: buffered words, 0..3.
  - `pend`: `fifo_r_en` delayed one cycle; means `fifo_data` holds a word not yet captured.
  - 3-entry circular buffer with 2-bit `wr_idx` and `rd_idx`, each wrapping 2→0.
- Issue rule: `fifo_r_en = rst_n & !fifo_empty & (cnt + pend <= 2)`. This is combinational from registered state and `fifo_empty` only.
- Capture: when `pend` = 1 at an edge, write `fifo_data` into `buf[wr_idx]` and advance `wr_idx`.
- Pop: when `m_valid & m_ready` at an edge, advance `rd_idx`.
- Count update: `cnt_next = cnt + pend - (m_valid & m_ready)`.
  - Simultaneous capture and pop leaves `cnt` unchanged.
  - Capture when `cnt` = 3 is unreachable by the issue rule; the bench asserts it never occurs.
- Outputs:
  - `m_valid = (cnt != 0)`.
  - `m_data = buf[rd_idx]`.
  - `m_data` is held stable while `m_valid & !m_ready` (standard valid/ready: no retraction, no change).
- Ordering: words leave in exact FIFO read order.
- Reset (asynchronous, any time including mid-transfer):
  - `cnt`, `pend`, `wr_idx`, `rd_idx` → 0.
  - Buffer contents → 0.
  - Outputs: `m_valid` 0, `m_data` 0, `fifo_r_en` 0 while `rst_n` is low, `word_count` 0.
  - In-flight words are discarded. The FIFO is reset by the same `rst_n`.

## Timing
- Latency: `fifo_r_en` high in cycle t → `fifo_data` valid in cycle t+1 → captured at the edge ending t+1 → `m_valid` high in cycle t+2.
- Empty FIFO to first output: a word written into an empty FIFO at edge e produces `m_valid` 3 cycles after e (2 from the first `fifo_r_en`).
- Throughput: with `m_ready` held 1 and the FIFO non-empty, steady state is `cnt` = 1, `pend` = 1, giving one word per cycle indefinitely.
- Backpressure: with `m_ready` = 0, at most 3 reads are issued. `cnt` saturates at 3 and `fifo_r_en` stays low until a pop brings `cnt + pend` ≤ 2.
- Refill bubble: after `m_ready` returns to 1, output stays continuous. 3 buffered words cover the 2-cycle refill latency.
- FIFO goes empty mid-stream: `fifo_r_en` drops the same cycle. `m_valid` drops after the buffer drains. No spurious beat is produced, because `pend` is set only by an actual `fifo_r_en`.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `word_count` increments by 1 at every edge where `m_valid & m_ready`.
  - Unsigned 32-bit; wraps 0xFFFF_FFFF → 0.
  - Reset to 0.
- Not defined:
  - `word_count` is tied to 0 and no counter logic is synthesized.
  - All other behaviour is identical.

## Test plan
- Single word: write 0xA5A5 into an empty FIFO, `m_ready` = 1 → one `fifo_r_en` pulse, `m_valid` for exactly 1 cycle with `m_data` = 0xA5A5 two cycles after the pulse, then idle.
- Streaming: preload 8 words 0x0001..0x0008, `m_ready` = 1 → 8 consecutive `m_valid` cycles, data in order, no gaps after the first.
- Backpressure: preload 8 words, `m_ready` = 0 for 10 cycles → exactly 3 `fifo_r_en` pulses, `cnt` = 3, `m_data` = 0x0001 held. Then `m_ready` = 1 → remaining 8 beats gap-free and in order.
- Random `m_ready` (50%), 200 random words through the FIFO → scoreboard exact match; `m_data` never changes while stalled.
- Reset mid-stream: assert `rst_n` = 0 with `cnt` = 2 and `pend` = 1 → `m_valid`, `fifo_r_en`, `m_data` go to 0 immediately. After release, the next written word 0x1234 is the first beat output.
- With `FIFO_RD_STATS_EN`: preset counter to 0xFFFF_FFFE, send 3 beats → `word_count` = 0x0000_0001. Without the macro → `word_count` stays 0.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready output stream, bundled for the read-side adapter.
// master = adapter side, slave = FIFO / downstream side.
interface fifo_rd_stream_adapter_if #(
    parameter int fifo_width = 16
);
    logic                  fifo_empty;
    logic                  fifo_r_en;
    logic [fifo_width-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [fifo_width-1:0] m_data;
    logic [31:0]           word_count;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data, word_count
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data, word_count
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side adapter: one-cycle-latency FIFO read port to valid/ready stream via a 3-entry skid buffer.
// Optional accepted-beat counter on word_count when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream_adapter #(
    parameter int fifo_width = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fifo_rd_stream_adapter_if.master  bus
);
    logic [1:0]            cnt;
    logic                  pend;
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [fifo_width-1:0] mem_q [3];
    logic [fifo_width-1:0] m_data_c;
    logic [2:0]            occ;
    logic                  pop;

    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A read is only issued if a slot is guaranteed when its data lands next cycle.
    assign occ           = {1'b0, cnt} + {2'b00, pend};
    assign bus.fifo_r_en = rst_n & ~bus.fifo_empty & (occ <= 3'd2);
    assign bus.m_valid   = (cnt != 2'd0);
    assign pop           = bus.m_valid & bus.m_ready;

    always_comb begin
        m_data_c = '0;
        case (rd_idx)
            2'd0:    m_data_c = mem_q[0];
            2'd1:    m_data_c = mem_q[1];
            2'd2:    m_data_c = mem_q[2];
            default: m_data_c = '0;
        endcase
    end
    assign bus.m_data = m_data_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            pend   <= 1'b0;
            wr_idx <= 2'd0;
            rd_idx <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pend <= bus.fifo_r_en;
            cnt  <= cnt + {1'b0, pend} - {1'b0, pop};
            if (pend) begin
                mem_q[wr_idx] <= bus.fifo_data;
                wr_idx        <= idx_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= idx_inc(rd_idx);
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= 32'd0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign bus.word_count = word_cnt_q;
`else
    assign bus.word_count = 32'd0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural synchronous FIFO in front of it.
module tb_fifo_rd_stream_adapter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_rd_stream_adapter_if #(.fifo_width(16)) bus();

    fifo_rd_stream_adapter #(.fifo_width(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: registered empty flag, registered one-cycle read data.
    logic [15:0] mem [512];
    logic [8:0]  wr_ptr = 9'd0;
    logic [8:0]  rd_ptr;
    int          underflow = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr         <= wr_ptr;
            bus.fifo_data  <= 16'h0000;
            bus.fifo_empty <= 1'b1;
        end else if (bus.fifo_r_en) begin
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
            bus.fifo_data  <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 9'd1;
            bus.fifo_empty <= ((rd_ptr + 9'd1) == wr_ptr);
        end else begin
            bus.fifo_empty <= (rd_ptr == wr_ptr);
        end
    end

    // Monitor: logs read pulses and accepted beats, counts protocol violations.
    int          cyc = 0;
    int          ren_cnt = 0;
    int          last_ren_cyc = 0;
    int          beat_n = 0;
    logic [15:0] beat_data [512];
    int          beat_cyc [512];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    int          hold_viol = 0;
    int          cap3_viol = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.fifo_r_en) begin
                ren_cnt      <= ren_cnt + 1;
                last_ren_cyc <= cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                beat_data[beat_n] <= bus.m_data;
                beat_cyc[beat_n]  <= cyc;
                beat_n            <= beat_n + 1;
            end
            if (prev_stall && (!bus.m_valid || bus.m_data != prev_data)) hold_viol <= hold_viol + 1;
            if (dut.pend && dut.cnt == 2'd3) cap3_viol <= cap3_viol + 1;
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 9'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] exp_words [200];

    initial begin
        int b0;
        int r0;
        int pushed;
        int budget;
        logic reached;

        bus.m_ready = 1'b0;
        cycles(3);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        chk("rst_m_data", {16'd0, bus.m_data}, 32'd0);
        chk("rst_word_count", bus.word_count, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // single word
        b0 = beat_n; r0 = ren_cnt;
        bus.m_ready = 1'b1;
        push(16'hA5A5);
        cycles(8);
        chk("single_ren", ren_cnt - r0, 32'd1);
        chk("single_beats", beat_n - b0, 32'd1);
        chk("single_data", {16'd0, beat_data[b0]}, 32'h0000_A5A5);
        chk("single_latency", beat_cyc[b0] - last_ren_cyc, 32'd2);
        chk("single_idle", {31'd0, bus.m_valid}, 32'd0);

        // streaming
        b0 = beat_n;
        for (int i = 1; i <= 8; i++) push(16'(i));
        cycles(16);
        chk("stream_beats", beat_n - b0, 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("stream_data%0d", i), {16'd0, beat_data[b0+i]}, 32'(i + 1));
        chk("stream_span", beat_cyc[b0+7] - beat_cyc[b0], 32'd7);

        // backpressure
        b0 = beat_n; r0 = ren_cnt;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i));
        cycles(10);
        chk("bp_ren", ren_cnt - r0, 32'd3);
        chk("bp_cnt", {30'd0, dut.cnt}, 32'd3);
        chk("bp_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("bp_data_held", {16'd0, bus.m_data}, 32'h0000_0001);
        bus.m_ready = 1'b1;
        cycles(20);
        chk("bp_beats", beat_n - b0, 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_data%0d", i), {16'd0, beat_data[b0+i]}, 32'(i + 1));
        chk("bp_span", beat_cyc[b0+7] - beat_cyc[b0], 32'd7);

        // random m_ready, 200 random words
        b0 = beat_n; pushed = 0; budget = 3000;
        while ((beat_n - b0) < 200 && budget > 0) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                exp_words[pushed] = 16'($urandom);
                push(exp_words[pushed]);
                pushed++;
            end
            cycles(1);
            budget--;
        end
        bus.m_ready = 1'b1;
        cycles(4);
        chk("rand_beats", beat_n - b0, 32'd200);
        for (int i = 0; i < 200; i++) chk($sformatf("rand_data%0d", i), {16'd0, beat_data[b0+i]}, {16'd0, exp_words[i]});

        // reset mid-stream with cnt=2, pend=1
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'h0100 + 16'(i));
        reached = 1'b0; budget = 30;
        while (!reached && budget > 0) begin
            cycles(1);
            reached = (dut.cnt == 2'd2) && dut.pend;
            budget--;
        end
        chk("mid_reach_cnt2_pend1", {31'd0, reached}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("mid_rst_ren", {31'd0, bus.fifo_r_en}, 32'd0);
        chk("mid_rst_data", {16'd0, bus.m_data}, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        b0 = beat_n;
        bus.m_ready = 1'b1;
        push(16'h1234);
        cycles(10);
        chk("post_rst_beats", beat_n - b0, 32'd1);
        chk("post_rst_data", {16'd0, beat_data[b0]}, 32'h0000_1234);

`ifdef FIFO_RD_STATS_EN
        force dut.word_cnt_q = 32'hFFFF_FFFE;
        cycles(1);
        release dut.word_cnt_q;
        for (int i = 0; i < 3; i++) push(16'h0200 + 16'(i));
        cycles(10);
        chk("stats_wrap", bus.word_count, 32'h0000_0001);
`else
        chk("stats_off", bus.word_count, 32'd0);
`endif

        chk("hold_violations", hold_viol, 32'd0);
        chk("capture_at_cnt3", cap3_viol, 32'd0);
        chk("fifo_underflow", underflow, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
